// File: rtl/svr_fifo_if.sv
// svr_fifo_if
//   Valid/ready word channel used on both sides of svr_fifo.
//   data  : transferred word
//   valid : sender has a word on data
//   ready : receiver can take the word this cycle
//   modport master : drives data/valid, observes ready
//   modport slave  : observes data/valid, drives ready
interface svr_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/svr_fifo.sv
// svr_fifo
//   First-word-fall-through valid/ready FIFO with fully registered outputs,
//   intended to sit directly upstream of a monitored link.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   flush : synchronous clear of all stored words (beats push and pop)
//   s     : producer side (slave modport): s.data, s.valid in, s.ready out
//   m     : consumer side (master modport): m.data, m.valid out, m.ready in
//   count : number of stored words including the head word
module svr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    svr_fifo_if.slave                  s,
    svr_fifo_if.master                 m,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  m_valid_q, m_valid_d;
    logic                  s_ready_q, s_ready_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic                  push;
    logic                  pop;
    logic [PW-1:0]         fill;

    always_comb begin
        push = s.valid && s_ready_q && !flush;
        pop  = m_valid_q && m.ready && !flush;

        wr_ptr_d = wr_ptr_q + PW'(push);
        // Flush empties the FIFO by snapping the read pointer to the write pointer.
        rd_ptr_d = flush ? wr_ptr_q : (rd_ptr_q + PW'(pop));

        // Extra pointer MSB makes the modulo-2*DEPTH difference the exact fill level.
        fill      = wr_ptr_d - rd_ptr_d;
        count_d   = CW'(fill);
        m_valid_d = (fill != '0);
        s_ready_d = (count_d < DEPTH_C);

        // The head register only changes when a new word becomes the head:
        // after a pop, or when an empty FIFO receives a word. Otherwise it holds,
        // which also keeps m_data stable under backpressure and across flush.
        m_data_d = m_data_q;
        if (m_valid_d && (pop || !m_valid_q)) begin
            // New head is the word being written this very edge: bypass storage.
            if (rd_ptr_d == wr_ptr_q) begin
                m_data_d = s.data;
            end else begin
                m_data_d = mem[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            m_data_q  <= m_data_d;
        end
    end

    // Storage carries no reset; only entries behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= s.data;
        end
    end

    assign s.ready = s_ready_q;
    assign m.valid = m_valid_q;
    assign m.data  = m_data_q;
    assign count   = count_q;

endmodule

// File: doc/svr_fifo.md
Name: svr_fifo

Overview:
- Synchronous valid/ready FIFO stage placed directly upstream of a svr_if-monitored link.
- Accepts words from a producer on the slave side and drives the monitored link from its master side.
- Registered outputs decouple timing between producer and consumer.
- Master-side outputs meet the link rules by construction: no X on m_valid or m_data while handshaking, and m_data stable while m_valid is high and m_ready is low.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- DEPTH, 4, number of entries; power of two, 2 to 256.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stored entries.
- s_data  input  DATA_WIDTH  producer data.
- s_valid  input  1  producer word valid.
- s_ready  output  1  FIFO can accept a word; registered.
- m_data  output  DATA_WIDTH  head-of-FIFO data; registered.
- m_valid  output  1  head word valid; registered.
- m_ready  input  1  consumer accepts the head word.
- count  output  $clog2(DEPTH+1)  number of stored words, including the head; registered.

Behaviour:
- Reset (rst low, asynchronous):
  - m_valid=0, m_data=0, count=0, s_ready=0.
  - Read and write pointers are set to 0.
  - s_ready rises on the first clk edge after rst goes high.
- Handshakes:
  - Push happens on an edge where s_valid && s_ready.
  - Pop happens on an edge where m_valid && m_ready.
  - Push and pop may occur in the same cycle.
- s_ready:
  - s_ready = (count_next < DEPTH), registered.
  - No combinational path from m_ready to s_ready or from s_valid to m_valid.
  - When full, a simultaneous pop does not allow a push that cycle; s_ready returns high the following cycle.
- Ordering and latency:
  - First-word-fall-through, strict FIFO order.
  - Push into an empty FIFO: m_valid=1 with m_data=s_data on the next edge (latency 1).
  - Push and pop in the same cycle: count is unchanged; the next entry becomes the head on that edge.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_valid hold their values regardless of pushes.
- m_valid never deasserts without a pop or a flush.
- Storage:
  - Pointers are $clog2(DEPTH)+1 bits wide.
  - The MSB distinguishes full from empty, and pointers wrap modulo 2*DEPTH.
  - Storage is indexed by the low bits.
  - count = wr_ptr - rd_ptr and never exceeds DEPTH.
- Push when full: not possible, because s_ready=0 then. A producer holding s_valid stalls.
- Pop when empty: not possible, because m_valid=0 then.
- m_ready while m_valid=0: ignored.
- Flush (takes priority over push and pop in that cycle):
  - On the next edge: count=0, pointers equal, m_valid=0, s_ready=1.
  - m_data holds its last value and is not cleared.
  - A push or pop handshake coinciding with flush is discarded and does not count as a transfer.
- Reset mid-operation: all contents are lost. After release the FIFO is empty and no stale word appears on m_valid.
- Storage array needs no reset. m_data must never present an unwritten entry while m_valid=1.

Test Plan:
- Reset release and single word:
  - Stimulus: hold rst=0 for 3 cycles, release, push 0xA5A5_0001 on the first s_ready=1 cycle, m_ready=1.
  - Response: m_valid=1, m_data=0xA5A5_0001 one cycle after the push; count goes 1 then 0.
- Fill to full and drain (DEPTH=4, m_ready=0):
  - Stimulus: push 0x10, 0x11, 0x12, 0x13, hold s_valid with 0x14, then set m_ready=1.
  - Response: s_ready=0 once count=4, and 0x14 is not accepted. Output order is 0x10..0x13, then 0x14 after s_ready returns.
- Backpressure stability:
  - Stimulus: m_valid=1 with head 0xDEAD_BEEF, m_ready=0 for 5 cycles while pushes continue.
  - Response: m_data=0xDEAD_BEEF every cycle, and the svr_if stable_when_valid assertion never fires.
- Simultaneous push/pop at count=2:
  - Stimulus: 8 consecutive cycles with s_valid=1 and m_ready=1.
  - Response: count stays 2, output is in order with no gaps, and pointers wrap with no corruption.
- Flush while full with m_ready=1:
  - Stimulus: assert flush for 1 cycle.
  - Response: next cycle count=0, m_valid=0, s_ready=1. The popped word in the flush cycle is discarded, and a push right after flush appears at the head 1 cycle later.
- Random traffic:
  - Stimulus: 10k cycles of random s_valid, m_ready and flush (1%), with an async rst pulse mid-run.
  - Response: the scoreboard order matches, and there are no svr_if assertion warnings.
